cam_cmd_serializer: RTL

CAM_CMD_SERIALIZER -- requirements
Module: cam_cmd_serializer

---
 rtl/cam_cmd_serializer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cam_cmd_serializer.sv
// Command serializer: accepts one CAM command, streams its key MS-beat first on the
// port group selected by the command type, then performs the action-table write and pulses done.
module cam_cmd_serializer #(
  parameter int LOOK_UP_DATA_WIDTH  = 280,
  parameter int PORT_MNG_DATA_WIDTH = 8,
  parameter int CAM_NUM             = 1024,
  localparam int BEATS = LOOK_UP_DATA_WIDTH / PORT_MNG_DATA_WIDTH,
  localparam int CW    = $clog2(BEATS),
  localparam int AW    = $clog2(CAM_NUM)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_cmd_vld,
  output logic                           o_cmd_rdy,
  input  logic [1:0]                     i_cmd_type,
  input  logic [LOOK_UP_DATA_WIDTH-1:0]  i_cmd_key,
  input  logic [AW-1:0]                  i_cmd_addr,
  input  logic [23:0]                    i_cmd_action,
  input  logic                           i_stall,
  output logic [PORT_MNG_DATA_WIDTH-1:0] o_look_up_data,
  output logic [PORT_MNG_DATA_WIDTH-1:0] o_config_data,
  output logic [PORT_MNG_DATA_WIDTH-1:0] o_change_data,
  output logic [PORT_MNG_DATA_WIDTH-1:0] o_delete_data,
  output logic [CW-1:0]                  o_look_up_data_cnt,
  output logic [CW-1:0]                  o_config_data_cnt,
  output logic [CW-1:0]                  o_change_data_cnt,
  output logic [CW-1:0]                  o_delete_data_cnt,
  output logic                           o_look_up_data_vld,
  output logic                           o_config_data_vld,
  output logic                           o_change_data_vld,
  output logic                           o_delete_data_vld,
  output logic                           o_action_wea,
  output logic [AW-1:0]                  o_action_addra,
  output logic [23:0]                    o_action_din,
  output logic                           o_cmd_done
);

  localparam int KW = LOOK_UP_DATA_WIDTH;
  localparam int PW = PORT_MNG_DATA_WIDTH;
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BEATS - 1);
  localparam logic [1:0]    CMD_LOOKUP = 2'd0;
  localparam logic [1:0]    CMD_DELETE = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, ACTION, DONE} state_t;

  state_t          state_r, state_n;
  logic [CW-1:0]   next_beat_r, next_beat_n;
  logic            last_sent_r, last_sent_n;
  logic [KW-1:0]   key_r, key_n;
  logic [1:0]      type_r, type_n;
  logic [AW-1:0]   addr_r, addr_n;
  logic [23:0]     action_r, action_n;
  logic            wea_r, wea_n;
  logic [AW-1:0]   addra_r, addra_n;
  logic [23:0]     din_r, din_n;
  logic            done_r, done_n;

  logic            beat_vld_s;
  logic [PW-1:0]   beat_data_s;
  logic [CW-1:0]   beat_cnt_s;

  logic [PW-1:0]   grp_data_r [4];
  logic [PW-1:0]   grp_data_n [4];
  logic [CW-1:0]   grp_cnt_r  [4];
  logic [CW-1:0]   grp_cnt_n  [4];
  logic [3:0]      grp_vld_r, grp_vld_n;

  assign o_cmd_rdy = (state_r == IDLE) && !i_rst;

  // Next-state and next-output computation; the key is shifted so the MS beat is always on top.
  always_comb begin
    state_n     = state_r;
    next_beat_n = next_beat_r;
    last_sent_n = last_sent_r;
    key_n       = key_r;
    type_n      = type_r;
    addr_n      = addr_r;
    action_n    = action_r;
    beat_vld_s  = 1'b0;
    beat_data_s = '0;
    beat_cnt_s  = '0;
    wea_n       = 1'b0;
    addra_n     = addra_r;
    din_n       = din_r;
    done_n      = 1'b0;

    case (state_r)
      IDLE: begin
        if (i_cmd_vld && o_cmd_rdy) begin
          type_n      = i_cmd_type;
          addr_n      = i_cmd_addr;
          action_n    = i_cmd_action;
          key_n       = i_cmd_key << PW;
          beat_vld_s  = 1'b1;
          beat_data_s = i_cmd_key[KW-1 -: PW];
          beat_cnt_s  = '0;
          next_beat_n = CW'(1);
          last_sent_n = 1'b0;
          state_n     = SEND;
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (last_sent_r) begin
          state_n = (type_r == CMD_LOOKUP) ? DONE : ACTION;
        end else if (i_stall) begin
          beat_cnt_s = next_beat_r;
        end else begin
          beat_vld_s  = 1'b1;
          beat_data_s = key_r[KW-1 -: PW];
          beat_cnt_s  = next_beat_r;
          key_n       = key_r << PW;
          if (next_beat_r == LAST_BEAT) begin
            last_sent_n = 1'b1;
          end else begin
            next_beat_n = next_beat_r + CW'(1);
          end
        end
      end
      ACTION:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n == ACTION) begin
      wea_n   = 1'b1;
      addra_n = addr_r;
      din_n   = (type_r == CMD_DELETE) ? 24'h0 : action_r;
    end else begin
      wea_n = 1'b0;
    end

    done_n = (state_n == DONE);

    // Only the group named by the command type ever carries a non-zero value.
    for (int i = 0; i < 4; i++) begin
      if ((state_n == SEND) && (type_n == i[1:0])) begin
        grp_vld_n[i]  = beat_vld_s;
        grp_data_n[i] = beat_data_s;
        grp_cnt_n[i]  = beat_cnt_s;
      end else begin
        grp_vld_n[i]  = 1'b0;
        grp_data_n[i] = '0;
        grp_cnt_n[i]  = '0;
      end
    end
  end

  // State, command context and all output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= IDLE;
      next_beat_r <= '0;
      last_sent_r <= 1'b0;
      key_r       <= '0;
      type_r      <= 2'd0;
      addr_r      <= '0;
      action_r    <= 24'h0;
      wea_r       <= 1'b0;
      addra_r     <= '0;
      din_r       <= 24'h0;
      done_r      <= 1'b0;
      grp_vld_r   <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        grp_data_r[i] <= '0;
        grp_cnt_r[i]  <= '0;
      end
    end else begin
      state_r     <= state_n;
      next_beat_r <= next_beat_n;
      last_sent_r <= last_sent_n;
      key_r       <= key_n;
      type_r      <= type_n;
      addr_r      <= addr_n;
      action_r    <= action_n;
      wea_r       <= wea_n;
      addra_r     <= addra_n;
      din_r       <= din_n;
      done_r      <= done_n;
      grp_vld_r   <= grp_vld_n;
      for (int i = 0; i < 4; i++) begin
        grp_data_r[i] <= grp_data_n[i];
        grp_cnt_r[i]  <= grp_cnt_n[i];
      end
    end
  end

  assign o_look_up_data     = grp_data_r[0];
  assign o_config_data      = grp_data_r[1];
  assign o_change_data      = grp_data_r[2];
  assign o_delete_data      = grp_data_r[3];
  assign o_look_up_data_cnt = grp_cnt_r[0];
  assign o_config_data_cnt  = grp_cnt_r[1];
  assign o_change_data_cnt  = grp_cnt_r[2];
  assign o_delete_data_cnt  = grp_cnt_r[3];
  assign o_look_up_data_vld = grp_vld_r[0];
  assign o_config_data_vld  = grp_vld_r[1];
  assign o_change_data_vld  = grp_vld_r[2];
  assign o_delete_data_vld  = grp_vld_r[3];
  assign o_action_wea       = wea_r;
  assign o_action_addra     = addra_r;
  assign o_action_din       = din_r;
  assign o_cmd_done         = done_r;

endmodule
